// File: rtl/axis2ccd.sv
// AXI-Stream line input to CCD-style pixel stream: pads each line with dummy words,
// inserts idle gaps between lines and flags protocol errors on the input side.
module axis2ccd #(
   parameter int                    DATA_WIDTH      = 12,
   parameter int                    EFFECT_COLS     = 2048,
   parameter int                    PRE_DUMMY_COLS  = 32,
   parameter int                    POST_DUMMY_COLS = 8,
   parameter int                    LINE_GAP        = 16,
   parameter logic [DATA_WIDTH-1:0] DUMMY_VALUE     = '0
) (
   input  logic                  pixel_clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   input  logic [10:0]           rows,
   output logic                  tvalid,
   output logic [DATA_WIDTH-1:0] tdata,
   output logic                  frame_done,
   output logic                  err
);

   // state    | meaning
   // WAIT_SOF | discard beats until a tuser beat starts a frame
   // PRE      | emit leading dummy words
   // EFF      | pass effective pixels (or fill with dummies after early tlast)
   // POST     | emit trailing dummy words
   // GAP      | idle cycles between lines
   typedef enum logic [2:0] {WAIT_SOF, PRE, EFF, POST, GAP} state_t;

   localparam logic [11:0] EFF_M1  = 12'(EFFECT_COLS - 1);
   localparam logic [11:0] PRE_M1  = 12'(PRE_DUMMY_COLS - 1);
   localparam logic [11:0] POST_M1 = 12'(POST_DUMMY_COLS - 1);
   localparam logic [11:0] GAP_M1  = 12'(LINE_GAP - 1);

   state_t                  state, state_nxt;
   logic [11:0]             col_cnt, cnt_nxt;
   logic [10:0]             line_cnt, line_nxt;
   logic [10:0]             rows_lat, rows_nxt;
   logic                    fill, fill_nxt;
   logic                    out_vld;
   logic [DATA_WIDTH-1:0]   out_dat;
   logic                    err_set, done_nxt;
   logic                    line_done, post_done, gap_done, to_pre;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT_SOF;
         col_cnt    <= '0;
         line_cnt   <= '0;
         rows_lat   <= '0;
         fill       <= 1'b0;
         tvalid     <= 1'b0;
         tdata      <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         col_cnt    <= cnt_nxt;
         line_cnt   <= line_nxt;
         rows_lat   <= rows_nxt;
         fill       <= fill_nxt;
         tvalid     <= out_vld;
         tdata      <= out_dat;
         frame_done <= done_nxt;
         err        <= err | err_set;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = col_cnt;
      line_nxt      = line_cnt;
      rows_nxt      = rows_lat;
      fill_nxt      = fill;
      out_vld       = 1'b0;
      out_dat       = tdata;
      err_set       = 1'b0;
      done_nxt      = 1'b0;
      line_done     = 1'b0;
      post_done     = 1'b0;
      gap_done      = 1'b0;
      to_pre        = 1'b0;
      s_axis_tready = 1'b0;

      case (state)
         WAIT_SOF: begin
            s_axis_tready = s_axis_tvalid & ~s_axis_tuser;
            if (s_axis_tvalid && s_axis_tuser) begin
               rows_nxt = (rows == 11'd0) ? 11'd1 : rows;
               line_nxt = '0;
               to_pre   = 1'b1;
            end
         end
         PRE: begin
            out_vld = 1'b1;
            out_dat = DUMMY_VALUE;
            if (col_cnt == 12'd0) begin
               state_nxt = EFF;
               cnt_nxt   = EFF_M1;
            end else begin
               cnt_nxt = col_cnt - 12'd1;
            end
         end
         EFF: begin
            s_axis_tready = ~fill;
            if (fill) begin
               out_vld = 1'b1;
               out_dat = DUMMY_VALUE;
               if (col_cnt == 12'd0) line_done = 1'b1;
               else cnt_nxt = col_cnt - 12'd1;
            end else if (s_axis_tvalid) begin
               out_vld = 1'b1;
               out_dat = s_axis_tdata;
               // only the first pixel of line 0 may carry SOF
               if (s_axis_tuser && !(line_cnt == 11'd0 && col_cnt == EFF_M1)) err_set = 1'b1;
               if (col_cnt == 12'd0) begin
                  if (!s_axis_tlast) err_set = 1'b1;
                  line_done = 1'b1;
               end else begin
                  if (s_axis_tlast) begin
                     err_set  = 1'b1;
                     fill_nxt = 1'b1;
                  end
                  cnt_nxt = col_cnt - 12'd1;
               end
            end
         end
         POST: begin
            out_vld = 1'b1;
            out_dat = DUMMY_VALUE;
            if (col_cnt == 12'd0) post_done = 1'b1;
            else cnt_nxt = col_cnt - 12'd1;
         end
         GAP: begin
            if (col_cnt == 12'd0) gap_done = 1'b1;
            else cnt_nxt = col_cnt - 12'd1;
         end
         default: state_nxt = WAIT_SOF;
      endcase

      // zero-length phases collapse into the following phase in the same cycle
      if (line_done) begin
         fill_nxt = 1'b0;
         if (POST_DUMMY_COLS != 0) begin
            state_nxt = POST;
            cnt_nxt   = POST_M1;
         end else begin
            post_done = 1'b1;
         end
      end
      if (post_done) begin
         line_nxt = line_cnt + 11'd1;
         if (LINE_GAP != 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_M1;
         end else begin
            gap_done = 1'b1;
         end
      end
      if (gap_done) begin
         if (line_nxt < rows_lat) begin
            to_pre = 1'b1;
         end else begin
            state_nxt = WAIT_SOF;
            done_nxt  = 1'b1;
         end
      end
      if (to_pre) begin
         fill_nxt = 1'b0;
         if (PRE_DUMMY_COLS != 0) begin
            state_nxt = PRE;
            cnt_nxt   = PRE_M1;
         end else begin
            state_nxt = EFF;
            cnt_nxt   = EFF_M1;
         end
      end
   end

endmodule
